// File: rtl/cal_builder_pkg.sv
// rtl/cal_builder_pkg.sv - shared calibration constants, FSM encodings and address helpers
package cal_builder_pkg;

  localparam int CAL_W         = 16;
  localparam int CAL_FRAC_BITS = 10;
  localparam int MULT_MAX      = 32767;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ACCUM    = 4'd1;
  localparam logic [3:0] ST_AVG      = 4'd2;
  localparam logic [3:0] ST_WR_SHIFT = 4'd3;
  localparam logic [3:0] ST_DIFF     = 4'd4;
  localparam logic [3:0] ST_DIV      = 4'd5;
  localparam logic [3:0] ST_CHECK    = 4'd6;
  localparam logic [3:0] ST_WR_MULT  = 4'd7;
  localparam logic [3:0] ST_FIN      = 4'd8;

  typedef enum logic {
    PT_ZERO = 1'b0,
    PT_REF  = 1'b1
  } cal_point_e;

  // cal_mem layout: even word = shift, odd word = multiply
  function automatic logic [3:0] shift_addr(input logic [2:0] ch);
    return {ch, 1'b0};
  endfunction

  function automatic logic [3:0] mult_addr(input logic [2:0] ch);
    return {ch, 1'b1};
  endfunction

endpackage

// File: rtl/cal_builder_if.sv
// rtl/cal_builder_if.sv - command/status and cal_mem write port bundle
interface cal_builder_if #(
  parameter int W = 16
) ();

  logic         cmd_start;
  logic         cmd_point;
  logic [2:0]   ch_sel;
  logic [W-1:0] cal_target;
  logic         busy;
  logic         done;
  logic         err;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;

  modport master (
    output cmd_start, cmd_point, ch_sel, cal_target,
    input  busy, done, err, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cmd_start, cmd_point, ch_sel, cal_target,
    output busy, done, err, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/cal_builder_divu.sv
// rtl/cal_builder_divu.sv - 32-bit restoring unsigned divider, one quotient bit per cycle
module cal_divu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_num,
  input  logic [31:0] i_den,
  output logic        o_busy,
  output logic        o_last,
  output logic        o_valid,
  output logic [31:0] o_quo
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_den;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_valid;
  logic [32:0] w_shift;
  logic [32:0] w_trial;

  // Dividend bits shift out of the quotient register into the remainder
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_den};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_den   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_start) begin
      r_rem   <= '0;
      r_quo   <= i_num;
      r_den   <= i_den;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
    end else if (r_busy) begin
      if (!w_trial[32]) begin
        r_rem <= w_trial[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shift[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_last  = r_busy && (r_cnt == 5'd31);
  assign o_valid = r_valid;
  assign o_quo   = r_quo;

endmodule

// File: rtl/cal_builder.sv
// rtl/cal_builder.sv - runtime calibration coefficient generator writing shift/mult words to cal_mem
module cal_builder
  import cal_builder_pkg::*;
#(
  parameter int W        = CAL_W,
  parameter int AVG_LOG2 = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_sample_clk,
  input  logic [W-1:0] i_in0,
  input  logic [W-1:0] i_in1,
  input  logic [W-1:0] i_in2,
  input  logic [W-1:0] i_in3,
  input  logic [W-1:0] i_in4,
  input  logic [W-1:0] i_in5,
  input  logic [W-1:0] i_in6,
  input  logic [W-1:0] i_in7,
  cal_builder_if.slave cal_bus
);

  localparam int AW = W + AVG_LOG2;

  logic [3:0]          r_state;
  logic                r_sample_d;
  logic [2:0]          r_ch;
  cal_point_e          r_point;
  logic [W-1:0]        r_target;
  logic [AW-1:0]       r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [W-1:0]        r_avg;
  logic [W-1:0]        r_lo [8];
  logic [7:0]          r_lo_valid;
  logic                r_err;

  logic                w_edge;
  logic [W-1:0]        w_in_sel;
  logic [W-1:0]        w_lo_sel;
  logic                w_sub;
  logic [AW-1:0]       w_add_a;
  logic [AW-1:0]       w_add_b;
  logic [AW-1:0]       w_sum;
  logic [W-1:0]        w_avg;
  logic [W:0]          w_diff;
  logic                w_diff_bad;
  logic [31:0]         w_num;
  logic [31:0]         w_den;
  logic                w_div_start;
  logic                w_div_busy;
  logic                w_div_last;
  logic                w_div_valid;
  logic [31:0]         w_quo;
  logic                w_quo_big;

  assign w_edge = i_sample_clk & ~r_sample_d;

  always_comb begin
    w_in_sel = i_in0;
    case (r_ch)
      3'd1:    w_in_sel = i_in1;
      3'd2:    w_in_sel = i_in2;
      3'd3:    w_in_sel = i_in3;
      3'd4:    w_in_sel = i_in4;
      3'd5:    w_in_sel = i_in5;
      3'd6:    w_in_sel = i_in6;
      3'd7:    w_in_sel = i_in7;
      default: w_in_sel = i_in0;
    endcase
  end

  assign w_lo_sel = r_lo[r_ch];

  // Single adder: accumulate in ACCUM, avg - lo (two's complement) in DIFF
  always_comb begin
    w_sub = (r_state == ST_DIFF);
    if (w_sub) begin
      w_add_a = {{AVG_LOG2{r_avg[W-1]}}, r_avg};
      w_add_b = ~{{AVG_LOG2{w_lo_sel[W-1]}}, w_lo_sel};
    end else begin
      w_add_a = r_acc;
      w_add_b = {{AVG_LOG2{w_in_sel[W-1]}}, w_in_sel};
    end
  end

  assign w_sum = w_add_a + w_add_b + {{(AW-1){1'b0}}, w_sub};

  // Slicing the accumulator is the arithmetic shift right, so it floors
  assign w_avg      = r_acc[AVG_LOG2 +: W];
  assign w_diff     = w_sum[W:0];
  assign w_diff_bad = w_diff[W] | (w_diff == '0) | r_target[W-1] | (r_target == '0);
  assign w_num      = {{(32-W){1'b0}}, r_target} << CAL_FRAC_BITS;
  assign w_den      = {{(31-W){1'b0}}, w_diff};
  assign w_div_start = (r_state == ST_DIFF) && !w_diff_bad;
  assign w_quo_big  = (w_quo > 32'(MULT_MAX));

  cal_divu u_divu (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (w_den),
    .o_busy  (w_div_busy),
    .o_last  (w_div_last),
    .o_valid (w_div_valid),
    .o_quo   (w_quo)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_sample_d <= 1'b0;
      r_ch       <= '0;
      r_point    <= PT_ZERO;
      r_target   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_avg      <= '0;
      r_lo_valid <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < 8; i++) r_lo[i] <= '0;
    end else begin
      r_sample_d <= i_sample_clk;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cal_bus.cmd_start) begin
            if (cal_bus.cmd_point && !r_lo_valid[cal_bus.ch_sel]) begin
              r_err <= 1'b1;
            end else begin
              r_ch     <= cal_bus.ch_sel;
              r_point  <= cal_point_e'(cal_bus.cmd_point);
              r_target <= cal_bus.cal_target;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (w_edge) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + AVG_LOG2'(1);
            if (r_cnt == '1) r_state <= ST_AVG;
          end
        end
        ST_AVG: begin
          r_avg <= w_avg;
          if (r_point == PT_ZERO) begin
            r_lo[r_ch]       <= w_avg;
            r_lo_valid[r_ch] <= 1'b1;
            r_state          <= ST_WR_SHIFT;
          end else begin
            r_state <= ST_DIFF;
          end
        end
        ST_WR_SHIFT: r_state <= ST_FIN;
        ST_DIFF: begin
          if (w_diff_bad) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (w_div_last || !w_div_busy) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_quo_big || !w_div_valid) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WR_MULT;
          end
        end
        ST_WR_MULT: r_state <= ST_FIN;
        ST_FIN:     r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign cal_bus.busy    = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign cal_bus.done    = (r_state == ST_FIN);
  assign cal_bus.err     = r_err;
  assign cal_bus.wr_en   = (r_state == ST_WR_SHIFT) || (r_state == ST_WR_MULT);
  assign cal_bus.wr_addr = (r_state == ST_WR_SHIFT) ? shift_addr(r_ch) :
                           (r_state == ST_WR_MULT)  ? mult_addr(r_ch)  : 4'd0;
  assign cal_bus.wr_data = (r_state == ST_WR_SHIFT) ? r_avg :
                           (r_state == ST_WR_MULT)  ? w_quo[W-1:0] : '0;

endmodule

// File: tb/tb_cal_builder.sv
// tb/tb_cal_builder.sv - directed self-checking bench for cal_builder with AVG_LOG2=2
module tb_cal_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic [15:0] tb_in [8];

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt, wr_a, wr_d, wr_c, done_cnt, done_c, err_cnt, err_c;

  cal_builder_if #(.W(16)) cal_bus ();

  cal_builder #(.W(16), .AVG_LOG2(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sample_clk (sclk),
    .i_in0        (tb_in[0]),
    .i_in1        (tb_in[1]),
    .i_in2        (tb_in[2]),
    .i_in3        (tb_in[3]),
    .i_in4        (tb_in[4]),
    .i_in5        (tb_in[5]),
    .i_in6        (tb_in[6]),
    .i_in7        (tb_in[7]),
    .cal_bus      (cal_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input int ch, input int pt, input int tgt);
    @(negedge clk);
    cal_bus.cmd_start  = 1'b1;
    cal_bus.ch_sel     = 3'(ch);
    cal_bus.cmd_point  = 1'(pt);
    cal_bus.cal_target = 16'(tgt);
    @(negedge clk);
    cal_bus.cmd_start  = 1'b0;
  endtask

  task automatic edge_s(input int ch, input int v, input bit last);
    tb_in[ch] = 16'(v);
    sclk = 1'b1;
    if (!last) begin
      @(negedge clk);
      sclk = 1'b0;
      @(negedge clk);
    end
  endtask

  // Cycle 1 is the first negedge after the clock that saw the last sample edge
  task automatic watch(input int ncyc);
    wr_cnt = 0; wr_a = -1; wr_d = -1; wr_c = -1;
    done_cnt = 0; done_c = -1; err_cnt = 0; err_c = -1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1) sclk = 1'b0;
      if (cal_bus.wr_en) begin
        wr_cnt++;
        wr_a = int'(cal_bus.wr_addr);
        wr_d = int'($signed(cal_bus.wr_data));
        wr_c = n;
      end
      if (cal_bus.done) begin done_cnt++; done_c = n; end
      if (cal_bus.err)  begin err_cnt++;  err_c  = n; end
    end
  endtask

  task automatic run_point(input int ch, input int pt, input int tgt,
                           input int v0, input int v1, input int v2, input int v3);
    cmd(ch, pt, tgt);
    edge_s(ch, v0, 1'b0);
    edge_s(ch, v1, 1'b0);
    edge_s(ch, v2, 1'b0);
    edge_s(ch, v3, 1'b1);
    watch(45);
  endtask

  initial begin
    cal_bus.cmd_start  = 1'b0;
    cal_bus.cmd_point  = 1'b0;
    cal_bus.ch_sel     = 3'd0;
    cal_bus.cal_target = 16'd0;
    for (int i = 0; i < 8; i++) tb_in[i] = 16'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy",  cal_bus.busy,    0);
    chk("rst_done",  cal_bus.done,    0);
    chk("rst_err",   cal_bus.err,     0);
    chk("rst_wr_en", cal_bus.wr_en,   0);
    chk("rst_addr",  cal_bus.wr_addr, 0);
    chk("rst_data",  cal_bus.wr_data, 0);
    rst = 1'b0;

    run_point(2, 0, 0, 100, 100, 100, 100);
    chk("zero_wr_cnt", wr_cnt, 1);
    chk("zero_addr",   wr_a, 4);
    chk("zero_data",   wr_d, 100);
    chk("zero_wr_cyc", wr_c, 2);
    chk("zero_done",   done_c, 3);
    chk("zero_done_n", done_cnt, 1);
    chk("zero_err",    err_cnt, 0);

    cmd(2, 1, 20000);
    chk("ref_busy", cal_bus.busy, 1);
    edge_s(2, 5100, 1'b0);
    cmd(6, 0, 0);
    edge_s(2, 5100, 1'b0);
    edge_s(2, 5100, 1'b0);
    edge_s(2, 5100, 1'b1);
    watch(45);
    chk("ref_wr_cnt", wr_cnt, 1);
    chk("ref_addr",   wr_a, 5);
    chk("ref_data",   wr_d, 4096);
    chk("ref_wr_cyc", wr_c, 36);
    chk("ref_done",   done_c, 37);
    chk("ref_err",    err_cnt, 0);

    run_point(2, 0, 0, 98, 102, 98, 102);
    chk("alt_addr", wr_a, 4);
    chk("alt_data", wr_d, 100);

    run_point(2, 0, 0, -3, -2, -2, -2);
    chk("floor_data", wr_d, -3);
    chk("floor_done", done_c, 3);

    run_point(2, 1, 20000, -53, -53, -53, -53);
    chk("neg_err",     err_cnt, 1);
    chk("neg_err_cyc", err_c, 3);
    chk("neg_wr",      wr_cnt, 0);
    chk("neg_done",    done_cnt, 0);

    run_point(2, 1, 20000, 97, 97, 97, 97);
    chk("ovf_err",     err_cnt, 1);
    chk("ovf_err_cyc", err_c, 36);
    chk("ovf_wr",      wr_cnt, 0);
    chk("ovf_done",    done_cnt, 0);

    cmd(5, 1, 20000);
    chk("nolo_err",  cal_bus.err, 1);
    chk("nolo_busy", cal_bus.busy, 0);
    @(negedge clk);
    chk("nolo_err_pulse", cal_bus.err, 0);
    watch(5);
    chk("nolo_wr", wr_cnt, 0);

    cmd(2, 0, 0);
    edge_s(2, 100, 1'b0);
    edge_s(2, 100, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_acc_busy", cal_bus.busy, 0);
    watch(10);
    chk("rst_acc_wr",   wr_cnt, 0);
    chk("rst_acc_done", done_cnt, 0);
    chk("rst_acc_err",  err_cnt, 0);
    cmd(2, 1, 20000);
    chk("rst_acc_lo_err", cal_bus.err, 1);

    run_point(2, 0, 0, 100, 100, 100, 100);
    chk("re_zero_done", done_cnt, 1);
    cmd(2, 1, 20000);
    edge_s(2, 5100, 1'b0);
    edge_s(2, 5100, 1'b0);
    edge_s(2, 5100, 1'b0);
    edge_s(2, 5100, 1'b1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) sclk = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_div_busy", cal_bus.busy, 0);
    watch(40);
    chk("rst_div_wr",   wr_cnt, 0);
    chk("rst_div_done", done_cnt, 0);
    chk("rst_div_err",  err_cnt, 0);
    cmd(2, 1, 20000);
    chk("rst_div_lo_err", cal_bus.err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
